line_buffer_5row: RTL
=====================

Name: line_buffer_5row

Overview:
- Raster-to-column converter feeding the 5x5 binary window stage (gaosi_filter).
- Takes a binary pixel stream, one pixel per enabled clock, in row-major order.
- Holds the last 4 image lines in 4 cascaded line memories.
- Each accepted pixel emits one vertical 5-pixel column (4 lines ago .. current) plus an enable, ready to drive the window's data_in_1..5 / en directly.

Parameters:
- IMG_W, 640, pixels per line (>= 2).
- IMG_H, 480, lines per frame (>= 5).
- DW, 1, bits per pixel (1 = binary image; kept generic for grey reuse).
- CW, 10, column counter width, must satisfy 2^CW >= IMG_W.
- RW, 9, row counter width, must satisfy 2^RW >= IMG_H.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse; next accepted pixel (or same-cycle pixel) is row 0, col 0.
- pix_valid  in  1  pixel qualifier.
- pix_data  in  DW  current pixel.
- row_out_1  out  DW  pixel from 4 lines above (top of window).
- row_out_2  out  DW  pixel from 3 lines above.
- row_out_3  out  DW  pixel from 2 lines above.
- row_out_4  out  DW  pixel from 1 line above.
- row_out_5  out  DW  current pixel (bottom of window).
- out_en  out  1  column valid; drives window en.
- win_valid  out  1  high with out_en when rows 1..4 hold real frame data (current row >= 4).
- out_col  out  CW  column index of the emitted column.
- out_row  out  RW  row index of row_out_5.
- frame_done  out  1  one-cycle pulse with the last column of a frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - All outputs 0.
  - col_cnt = 0, row_cnt = 0.
  - Line memories are not reset; win_valid qualifies their content.
- Storage:
  - mem0..mem3, each IMG_W x DW.
  - mem0 holds line n-1, mem3 holds line n-4.
  - Shared address = col_cnt.
- Per accepted pixel (pix_valid = 1), all updates on the same edge:
  - row_out_1 <= mem3[col], row_out_2 <= mem2[col], row_out_3 <= mem1[col], row_out_4 <= mem0[col], row_out_5 <= pix_data.
  - mem3[col] <= mem2[col], mem2[col] <= mem1[col], mem1[col] <= mem0[col], mem0[col] <= pix_data. Read-before-write; old values are used throughout.
  - out_en <= 1.
  - out_col <= col_cnt, out_row <= row_cnt.
  - win_valid <= (row_cnt >= 4).
  - frame_done <= (col_cnt == IMG_W-1 && row_cnt == IMG_H-1).
- Latency: exactly 1 clock from pixel to column.
- No accepted pixel:
  - out_en, win_valid, frame_done <= 0.
  - row_out_* and out_col/out_row hold their last values.
- Counters:
  - col_cnt increments per accepted pixel and wraps at IMG_W-1 to 0, which increments row_cnt.
  - row_cnt wraps at IMG_H-1 to 0 (frame end without frame_start keeps streaming).
- frame_start:
  - Forces col_cnt = row_cnt = 0.
  - If pix_valid is in the same cycle, that pixel is processed as row 0 col 0: counters become col 1, row 0.
  - Mid-line or mid-frame frame_start abandons the partial line.
  - Memory content is not cleared; win_valid stays 0 until row 4 of the new frame.
- No backpressure: the downstream window must accept every out_en.
- Reset mid-frame: everything returns to the reset state asynchronously; the next frame requires frame_start or starts at row 0 col 0.

Decomposition:
- Shared package (image_pkg): IMG_W/IMG_H defaults, the DW constant, and the CW/RW derivation (clog2) shared with gaosi_filter and the downstream threshold logic.
- One natural sub-module: line_mem, a single IMG_W x DW memory with registered read-before-write on a shared address.
  - Instantiate 4, cascaded mem(k) -> mem(k+1).
  - Counters and output registers stay in the top.

Test Plan:
- Config for all scenarios: IMG_W=8, IMG_H=6, DW=1. Stimulus is a continuous stream with pix_data = row[0] ^ col[0].
  - Row 4 col 3 emits row_out_1..5 = 1,0,1,0,1 with win_valid = 1, out_row = 4, out_col = 3.
  - Rows 0..3 emit win_valid = 0.
- Reset then frame_start with pixel 1 in the same cycle: next cycle out_en = 1, out_col = 0, out_row = 0, row_out_5 = 1, win_valid = 0.
- pix_valid toggling 1,0,1,0 across a line end: out_en follows with 1 cycle delay, row_out_* hold during gaps, col wraps 7 -> 0 and out_row increments.
- Full frame of 48 pixels: frame_done pulses exactly once, together with out_col = 7, out_row = 5. The 49th pixel reports row 0 col 0.
- frame_start at row 2 col 5: next pixel reports row 0 col 0. win_valid is first seen at new row 4 col 0, with 32 accepted pixels in the new frame before it.
- rst_n asserted mid-row-3: outputs go to 0 immediately without a clock. After release, the stream restarts at row 0 col 0 and win_valid is 0 until row 4.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: image geometry defaults shared by the line buffer, the 5x5
// window stage (gaosi_filter) and the downstream threshold logic.
//   IMG_W_DEF / IMG_H_DEF : default frame size in pixels / lines
//   DW_DEF                : default pixel width (1 = binary image)
//   CW_DEF / RW_DEF       : column / row counter widths derived from size
package image_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned DW_DEF    = 1;

  // Bits needed to index 0..n-1, never less than 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CW_DEF = idx_width(IMG_W_DEF);
  localparam int unsigned RW_DEF = idx_width(IMG_H_DEF);

endpackage

// File: rtl/line_mem.sv
// line_mem: one image line of storage (DEPTH x DW).
//   clk   : write clock
//   we    : write enable (one accepted pixel)
//   addr  : shared column address
//   wdata : value written at addr
//   rdata : current content at addr, read combinationally so the caller
//           sees the old value on the same edge that overwrites it
module line_mem #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 1,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Contents are deliberately not reset; the consumer qualifies them.
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    rdata = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_5row.sv
// line_buffer_5row: raster-to-column converter for the 5x5 binary window.
// Each accepted pixel emits, one clock later, the vertical column of five
// pixels (4 lines above .. current) at the same column position.
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_start         : restart at row 0 col 0 (same-cycle pixel included)
//   pix_valid, pix_data : raster pixel stream, row-major
//   row_out_1..5        : column, row_out_1 = oldest line, row_out_5 = current
//   out_en              : column valid
//   win_valid           : rows 1..4 hold data of the current frame
//   out_col, out_row    : position of row_out_5
//   frame_done          : pulse with the last column of a frame
module line_buffer_5row
  import image_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CW    = idx_width(IMG_W),
  parameter int unsigned RW    = idx_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic [DW-1:0] row_out_1,
  output logic [DW-1:0] row_out_2,
  output logic [DW-1:0] row_out_3,
  output logic [DW-1:0] row_out_4,
  output logic [DW-1:0] row_out_5,
  output logic          out_en,
  output logic          win_valid,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(4);

  logic [CW-1:0] col_cnt, eff_col, col_next;
  logic [RW-1:0] row_cnt, eff_row, row_next;
  logic          col_last, row_last;

  // tap[0] is the incoming pixel, tap[k] is the line k rows above.
  logic [DW-1:0] tap [5];

  // frame_start overrides the counters combinationally so a pixel arriving
  // in the same cycle is already treated as row 0 col 0.
  always_comb begin
    eff_col  = frame_start ? '0 : col_cnt;
    eff_row  = frame_start ? '0 : row_cnt;
    col_last = (eff_col == COL_LAST);
    row_last = (eff_row == ROW_LAST);
    col_next = col_last ? '0 : eff_col + CW'(1);
    row_next = eff_row;
    if (col_last) begin
      row_next = row_last ? '0 : eff_row + RW'(1);
    end
  end

  assign tap[0] = pix_data;

  // Cascade: each line memory shifts its old entry one line further up
  // while the same column is being read out.
  for (genvar k = 0; k < 4; k++) begin : g_line
    line_mem #(
      .DEPTH (IMG_W),
      .DW    (DW),
      .AW    (CW)
    ) u_line_mem (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (eff_col),
      .wdata (tap[k]),
      .rdata (tap[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_valid) begin
      col_cnt <= col_next;
      row_cnt <= row_next;
    end else if (frame_start) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out_1  <= '0;
      row_out_2  <= '0;
      row_out_3  <= '0;
      row_out_4  <= '0;
      row_out_5  <= '0;
      out_en     <= 1'b0;
      win_valid  <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_en     <= pix_valid;
      win_valid  <= pix_valid && (eff_row >= ROW_WIN);
      frame_done <= pix_valid && col_last && row_last;
      if (pix_valid) begin
        row_out_1 <= tap[4];
        row_out_2 <= tap[3];
        row_out_3 <= tap[2];
        row_out_4 <= tap[1];
        row_out_5 <= tap[0];
        out_col   <= eff_col;
        out_row   <= eff_row;
      end
    end
  end

endmodule
